mem_arb2: RTL and testbench
===========================

# mem_arb2

Two-master memory arbiter placed between the matmul engine and the shared word-addressed SRAM.
- Master 0 is the matmul engine (mem_* port).
- Master 1 is the host loader that fills the A and B matrices and drains C.
- The block serialises requests onto the single-port SRAM, honours its fixed read latency, and routes read data and acknowledgements back to the requester.

## Interface
Parameters:
- MEM_AW, 16, address width
- MEM_DW, 32, data width
- RD_LAT, 2, SRAM read latency in cycles, measured from the s_req cycle to the s_rdata-valid cycle (legal range 1..7)

Ports (m0_* and m1_* are identical bundles, listed once as mX_*):
- clk  in  1  single clock; all flops update on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- mX_req  in  1  request; held high with fields stable until mX_ack
- mX_write  in  1  1 = write, 0 = read
- mX_addr  in  MEM_AW  word address
- mX_wdata  in  MEM_DW  write data
- mX_ack  out  1  one-cycle pulse: write committed, or read data present
- mX_rdata_vld  out  1  one-cycle pulse with mX_ack on reads only
- mX_rdata  out  MEM_DW  read data, valid while mX_rdata_vld is high
- s_req  out  1  SRAM strobe, one cycle per access
- s_write  out  1  SRAM write enable
- s_addr  out  MEM_AW  SRAM address
- s_wdata  out  MEM_DW  SRAM write data
- s_rdata  in  MEM_DW  SRAM read data, valid RD_LAT cycles after s_req
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT_RD, ACK.
- IDLE
  - Sample m0_req and m1_req.
  - If neither is high, stay in IDLE.
  - Otherwise select a winner (see Configuration), latch its write, addr and wdata, and go to ISSUE.
- ISSUE
  - Assert s_req for exactly one cycle with the latched fields.
  - On a write, go to ACK.
  - On a read, load the latency counter with RD_LAT and go to WAIT_RD.
- WAIT_RD
  - Decrement the counter each cycle.
  - When it reaches 0, register s_rdata into the winner's mX_rdata and go to ACK.
- ACK
  - Pulse the winner's mX_ack for one cycle, plus mX_rdata_vld on a read.
  - Update the last-granted pointer, then return to IDLE.
- Only one transaction is outstanding at a time, so there is no reordering.
- mX_rdata holds its last value until the next read by the same master.
- A master must drop mX_req in the cycle after it sees mX_ack. Otherwise IDLE samples it again as a new request.
- The loser's request stays pending and is served in the next IDLE evaluation. No request is ever dropped.
- Changing the fields of a pending request before its ack is illegal. Behaviour is undefined; no checking is required.
- Reset mid-transaction:
  - The FSM goes to IDLE and all outputs clear.
  - An in-flight SRAM read is discarded.
  - A write already strobed is not undone.

## Timing
- Reset values:
  - All outputs are 0; mX_rdata is 0.
  - The state is IDLE and the last-granted pointer is 1, so master 0 wins the first tie.
- Write: request sampled in cycle N → s_req in cycle N+1 → mX_ack in cycle N+2. Throughput is one write every 3 cycles per master.
- Read: request sampled in cycle N → s_req in cycle N+1 → s_rdata sampled in cycle N+1+RD_LAT → mX_ack and mX_rdata_vld in cycle N+2+RD_LAT.
- With continuous demand from both masters, grants interleave with no idle gap beyond the mandatory IDLE cycle.
- busy is low only in the IDLE cycle.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. On a simultaneous request, the master other than the last-granted one wins. Neither master can starve the other.
- ARB_RR_EN undefined: fixed priority, master 0 always wins a tie. The last-granted pointer is not implemented, and master 1 is served only when m0_req is low in IDLE.

## Test plan
- Single write then read:
  - Stimulus: m1 writes 0xDEADBEEF to 0x0100, then reads 0x0100 with RD_LAT=2.
  - Required: s_req pulses at cycles N+1 and N+1 relative to each sample. m1_ack for the write arrives at N+2. For the read, m1_rdata_vld arrives at N+4 with data 0xDEADBEEF.
- Simultaneous reads:
  - Stimulus: m0 and m1 both request reads at the same cycle, from 0x0200 and 0x0300 respectively.
  - Required: m0 is served first. With ARB_RR_EN, m1 is served next. Each master gets its own data and m0_rdata_vld never accompanies m1 data.
- Starvation check:
  - Stimulus: m0 requests back-to-back continuously while m1 holds a single request.
  - Required with ARB_RR_EN: m1_ack within 2 grants.
  - Required without ARB_RR_EN: m1 is not served until m0_req drops.
- Latency sweep:
  - Stimulus: RD_LAT = 1, 3 and 7 against a model SRAM with matching latency.
  - Required: mX_rdata_vld exactly RD_LAT+2 cycles after the request is sampled, and data matches.
- Reset during WAIT_RD:
  - Stimulus: assert rst_n low mid-read.
  - Required: all outputs go to 0 immediately, with no ack after reset release. A fresh read then completes correctly.
- Integrated run:
  - Stimulus: the host loads a 6x4 A matrix at 0x100 and a 4x5 B matrix at 0x200, then matmul runs with C at 0x300 while the host polls C.
  - Required: all 30 C entries match the golden product, with 0 errors.

Source files
------------

// File: rtl/mem_arb2_if.sv
// Bus bundle for mem_arb2: two requester ports (m0 = matmul, m1 = host) plus the SRAM port.
interface mem_arb2_if #(
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32
);
    logic              m0_req, m0_write, m0_ack, m0_rdata_vld;
    logic [MEM_AW-1:0] m0_addr;
    logic [MEM_DW-1:0] m0_wdata, m0_rdata;

    logic              m1_req, m1_write, m1_ack, m1_rdata_vld;
    logic [MEM_AW-1:0] m1_addr;
    logic [MEM_DW-1:0] m1_wdata, m1_rdata;

    logic              s_req, s_write;
    logic [MEM_AW-1:0] s_addr;
    logic [MEM_DW-1:0] s_wdata, s_rdata;

    logic              busy;

    // arbiter side
    modport slave (
        input  m0_req, m0_write, m0_addr, m0_wdata,
        output m0_ack, m0_rdata_vld, m0_rdata,
        input  m1_req, m1_write, m1_addr, m1_wdata,
        output m1_ack, m1_rdata_vld, m1_rdata,
        output s_req, s_write, s_addr, s_wdata,
        input  s_rdata,
        output busy
    );

    // requester / SRAM-model side
    modport master (
        output m0_req, m0_write, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata_vld, m0_rdata,
        output m1_req, m1_write, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata_vld, m1_rdata,
        input  s_req, s_write, s_addr, s_wdata,
        output s_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arb2.sv
// Two-master arbiter serialising requests onto a fixed-latency single-port SRAM.
// Define ARB_RR_EN for round-robin arbitration; default build is fixed priority (m0 wins ties).
module mem_arb2 #(
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32,
    parameter int RD_LAT = 2     // 1..7, fits the 3-bit latency counter
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_arb2_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2, ACK = 2'd3} state_t;

    logic [1:0]             req, wr_in;
    logic [1:0][MEM_AW-1:0] addr_in;
    logic [1:0][MEM_DW-1:0] wdata_in;

    assign req      = {bus.m1_req,   bus.m0_req};
    assign wr_in    = {bus.m1_write, bus.m0_write};
    assign addr_in  = {bus.m1_addr,  bus.m0_addr};
    assign wdata_in = {bus.m1_wdata, bus.m0_wdata};

    state_t                 state_q, state_d;
    logic                   win_q, win_d;
    logic                   wr_q, wr_d;
    logic [MEM_AW-1:0]      addr_q, addr_d;
    logic [MEM_DW-1:0]      wdata_q, wdata_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [1:0][MEM_DW-1:0] rdata_q, rdata_d;

    logic                   sel;
    logic [1:0]             ack, vld;
    logic                   sreq, busy;

`ifdef ARB_RR_EN
    logic                   last_q, last_d;

    // On a tie the master that was not granted last time wins.
    always_comb begin
        sel = req[1];
        if (req[0] && req[1]) sel = ~last_q;
    end
`else
    always_comb begin
        sel = ~req[0];
    end
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ack     = '0;
        vld     = '0;
        sreq    = 1'b0;
        busy    = 1'b1;
`ifdef ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (|req) begin
                    win_d   = sel;
                    wr_d    = wr_in[sel];
                    addr_d  = addr_in[sel];
                    wdata_d = wdata_in[sel];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sreq = 1'b1;
                if (wr_q) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = 3'(RD_LAT);
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q - 3'd1;
                // Last wait cycle is the one in which the SRAM presents data.
                if (cnt_q <= 3'd1) begin
                    rdata_d[win_q] = bus.s_rdata;
                    state_d        = ACK;
                end
            end
            ACK: begin
                ack[win_q] = 1'b1;
                vld[win_q] = ~wr_q;
`ifdef ARB_RR_EN
                last_d     = win_q;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
`ifdef ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
`ifdef ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.m0_ack       = ack[0];
    assign bus.m0_rdata_vld = vld[0];
    assign bus.m0_rdata     = rdata_q[0];
    assign bus.m1_ack       = ack[1];
    assign bus.m1_rdata_vld = vld[1];
    assign bus.m1_rdata     = rdata_q[1];

    // SRAM fields are only driven during the strobe so the bus reads as zero otherwise.
    assign bus.s_req   = sreq;
    assign bus.s_write = sreq & wr_q;
    assign bus.s_addr  = sreq ? addr_q  : '0;
    assign bus.s_wdata = sreq ? wdata_q : '0;
    assign bus.busy    = busy;

    a_ack_excl : assert property (@(posedge clk) disable iff (!rst_n) !(ack[0] && ack[1]));
    a_sreq_one : assert property (@(posedge clk) disable iff (!rst_n) sreq |=> !sreq);
endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2: main instance at RD_LAT=2 plus a latency-sweep trio (1, 3, 7).
module tb_mem_arb2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- main DUT + SRAM model ----------------
    localparam int MLAT = 2;
    mem_arb2_if #(.MEM_AW(16), .MEM_DW(32)) bus ();
    mem_arb2 #(.MEM_AW(16), .MEM_DW(32), .RD_LAT(MLAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    bit   [31:0] sram [4096];
    logic [31:0] dp [MLAT];
    logic        vp [MLAT];
    always @(posedge clk) begin
        if (bus.s_req && bus.s_write) sram[bus.s_addr[11:0]] <= bus.s_wdata;
        dp[0] <= sram[bus.s_addr[11:0]];
        vp[0] <= bus.s_req && !bus.s_write;
        for (int i = 1; i < MLAT; i++) begin
            dp[i] <= dp[i-1];
            vp[i] <= vp[i-1];
        end
    end
    assign bus.s_rdata = vp[MLAT-1] ? dp[MLAT-1] : 32'hBADBAD00;

    int sreq_cyc = -1;
    int ack_n = 0;
    int bad_n = 0;
    always @(negedge clk) begin
        if (bus.s_req) sreq_cyc <= cyc;
        if (bus.m0_ack || bus.m1_ack) ack_n <= ack_n + 1;
        if ((bus.m0_ack && bus.m1_ack) || (bus.m0_rdata_vld && !bus.m0_ack) ||
            (bus.m1_rdata_vld && !bus.m1_ack)) bad_n <= bad_n + 1;
    end

    // One complete request/ack exchange on master m; called and returns at a negedge.
    task automatic xfer(input int m, input bit wr, input logic [15:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int ack_c, output bit vld);
        bit got = 0;
        rd = '0; ack_c = -1; vld = 0;
        if (m == 0) begin
            bus.m0_req = 1; bus.m0_write = wr; bus.m0_addr = a; bus.m0_wdata = wd;
        end else begin
            bus.m1_req = 1; bus.m1_write = wr; bus.m1_addr = a; bus.m1_wdata = wd;
        end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (m == 0 && bus.m0_ack) begin
                got = 1; vld = bus.m0_rdata_vld; rd = bus.m0_rdata; ack_c = cyc;
            end else if (m == 1 && bus.m1_ack) begin
                got = 1; vld = bus.m1_rdata_vld; rd = bus.m1_rdata; ack_c = cyc;
            end
        end
        if (m == 0) bus.m0_req = 0; else bus.m1_req = 0;
        chk("ack_seen", 64'(got), 64'd1);
    endtask

    // ---------------- latency sweep instances ----------------
    bit sw_go = 0;
    for (genvar g = 0; g < 3; g++) begin : swp
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 7;
        mem_arb2_if #(.MEM_AW(16), .MEM_DW(32)) sif ();
        mem_arb2 #(.MEM_AW(16), .MEM_DW(32), .RD_LAT(LAT)) u (.clk(clk), .rst_n(rst_n), .bus(sif));

        logic [31:0] sdp [LAT];
        logic        svp [LAT];
        always @(posedge clk) begin
            sdp[0] <= {sif.s_addr, ~sif.s_addr};
            svp[0] <= sif.s_req && !sif.s_write;
            for (int i = 1; i < LAT; i++) begin
                sdp[i] <= sdp[i-1];
                svp[i] <= svp[i-1];
            end
        end
        assign sif.s_rdata = svp[LAT-1] ? sdp[LAT-1] : 32'hBADBAD00;

        int          lat_r = -1;
        logic [31:0] dat_r = '0;
        bit          done = 0;
        int          n0 = 0;
        initial begin
            sif.m0_req = 0; sif.m0_write = 0; sif.m0_addr = '0; sif.m0_wdata = '0;
            sif.m1_req = 0; sif.m1_write = 0; sif.m1_addr = '0; sif.m1_wdata = '0;
            wait (sw_go);
            @(negedge clk);
            n0 = cyc;
            sif.m0_req  = 1;
            sif.m0_addr = 16'h0A00 + 16'(g);
            for (int i = 0; i < 50 && !done; i++) begin
                @(negedge clk);
                if (sif.m0_rdata_vld) begin
                    lat_r = cyc - n0; dat_r = sif.m0_rdata; done = 1;
                end
            end
            sif.m0_req = 0;
        end
    end

    // ---------------- directed sequence ----------------
    logic [31:0] r0, r1;
    int          c0, c1, n0, m0_done, m0_at, base, poll_n;
    bit          v0, v1, mm_done;
    logic [31:0] acc, av, gold;

    initial begin
        bus.m0_req = 0; bus.m0_write = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_write = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        #2 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {bus.busy, bus.s_req, bus.s_write, bus.m0_ack, bus.m1_ack,
                        bus.m0_rdata_vld, bus.m1_rdata_vld}, 64'd0);
        chk("rst_rd0", bus.m0_rdata, 64'd0);
        chk("rst_rd1", bus.m1_rdata, 64'd0);
        chk("rst_addr", {bus.s_addr, bus.s_wdata}, 64'd0);
        rst_n = 1;
        @(negedge clk);

        // latency sweep: vld exactly RD_LAT+2 after sampling
        sw_go = 1;
        for (int i = 0; i < 100 && !(swp[0].done && swp[1].done && swp[2].done); i++) @(negedge clk);
        chk("sweep1_lat", 64'(swp[0].lat_r), 64'd3);
        chk("sweep1_dat", swp[0].dat_r, 64'h0A00_F5FF);
        chk("sweep3_lat", 64'(swp[1].lat_r), 64'd5);
        chk("sweep3_dat", swp[1].dat_r, 64'h0A01_F5FE);
        chk("sweep7_lat", 64'(swp[2].lat_r), 64'd9);
        chk("sweep7_dat", swp[2].dat_r, 64'h0A02_F5FD);
        @(negedge clk);

        // single write then read by host
        n0 = cyc;
        xfer(1, 1, 16'h0100, 32'hDEADBEEF, r1, c1, v1);
        chk("wr_sreq_lat", 64'(sreq_cyc - n0), 64'd1);
        chk("wr_ack_lat", 64'(c1 - n0), 64'd2);
        chk("wr_vld", 64'(v1), 64'd0);
        chk("wr_mem", sram[12'h100], 64'hDEADBEEF);
        @(negedge clk);
        n0 = cyc;
        xfer(1, 0, 16'h0100, 32'h0, r1, c1, v1);
        chk("rd_sreq_lat", 64'(sreq_cyc - n0), 64'd1);
        chk("rd_ack_lat", 64'(c1 - n0), 64'd4);
        chk("rd_vld", 64'(v1), 64'd1);
        chk("rd_data", r1, 64'hDEADBEEF);
        @(negedge clk);
        chk("rd_hold", bus.m1_rdata, 64'hDEADBEEF);

        // simultaneous reads
        xfer(1, 1, 16'h0200, 32'h11110200, r1, c1, v1);
        xfer(1, 1, 16'h0300, 32'h22220300, r1, c1, v1);
        @(negedge clk);
        n0 = cyc;
        fork
            xfer(0, 0, 16'h0200, 32'h0, r0, c0, v0);
            xfer(1, 0, 16'h0300, 32'h0, r1, c1, v1);
        join
        chk("sim_m0_lat", 64'(c0 - n0), 64'd4);
        chk("sim_m1_lat", 64'(c1 - n0), 64'd9);
        chk("sim_m0_dat", r0, 64'h11110200);
        chk("sim_m1_dat", r1, 64'h22220300);
        chk("sim_m0_hold", bus.m0_rdata, 64'h11110200);

        // starvation: m0 back-to-back writes vs a single m1 read
        @(negedge clk);
        m0_done = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    xfer(0, 1, 16'h0400 + 16'(i), 32'hA0 + 32'(i), r0, c0, v0);
                    m0_done++;
                end
            end
            begin
                xfer(1, 0, 16'h0200, 32'h0, r1, c1, v1);
                m0_at = m0_done;
            end
        join
`ifdef ARB_RR_EN
        chk("starve_rr", 64'(m0_at), 64'd1);
`else
        chk("starve_fixed", 64'(m0_at), 64'd4);
`endif
        chk("starve_dat", r1, 64'h11110200);
        chk("starve_mem", sram[12'h403], 64'hA3);

        // reset during WAIT_RD
        @(negedge clk);
        bus.m0_req = 1; bus.m0_write = 0; bus.m0_addr = 16'h0100;
        repeat (2) @(negedge clk);
        chk("mid_busy", 64'(bus.busy), 64'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_ctl", {bus.busy, bus.s_req, bus.m0_ack, bus.m1_ack,
                            bus.m0_rdata_vld, bus.m1_rdata_vld}, 64'd0);
        chk("mid_rst_rd", {bus.m0_rdata, bus.m1_rdata}, 64'd0);
        bus.m0_req = 0;
        base = ack_n;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (10) @(negedge clk);
        chk("mid_no_ack", 64'(ack_n - base), 64'd0);
        n0 = cyc;
        xfer(0, 0, 16'h0300, 32'h0, r0, c0, v0);
        chk("post_rst_lat", 64'(c0 - n0), 64'd4);
        chk("post_rst_dat", r0, 64'h22220300);

        // integrated matmul: A 6x4 @0x100, B 4x5 @0x200, C 6x5 @0x300
        for (int i = 0; i < 6; i++)
            for (int k = 0; k < 4; k++)
                xfer(1, 1, 16'h0100 + 16'(i*4+k), 32'(i*4+k+1), r1, c1, v1);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 5; j++)
                xfer(1, 1, 16'h0200 + 16'(k*5+j), 32'((k+1)*(j+2)+3), r1, c1, v1);
        mm_done = 0;
        poll_n = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    for (int j = 0; j < 5; j++) begin
                        acc = 0;
                        for (int k = 0; k < 4; k++) begin
                            repeat (2) @(negedge clk);
                            xfer(0, 0, 16'h0100 + 16'(i*4+k), 32'h0, r0, c0, v0);
                            av = r0;
                            repeat (2) @(negedge clk);
                            xfer(0, 0, 16'h0200 + 16'(k*5+j), 32'h0, r0, c0, v0);
                            acc = acc + av * r0;
                        end
                        repeat (2) @(negedge clk);
                        xfer(0, 1, 16'h0300 + 16'(i*5+j), acc, r0, c0, v0);
                    end
                mm_done = 1;
            end
            begin
                while (!mm_done && poll_n < 300) begin
                    xfer(1, 0, 16'h0300 + 16'(poll_n % 30), 32'h0, r1, c1, v1);
                    poll_n++;
                end
            end
        join
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5; j++) begin
                gold = 0;
                for (int k = 0; k < 4; k++) gold = gold + 32'((i*4+k+1) * ((k+1)*(j+2)+3));
                xfer(1, 0, 16'h0300 + 16'(i*5+j), 32'h0, r1, c1, v1);
                chk("c_entry", r1, gold);
            end

        chk("ack_excl", 64'(bad_n), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end
endmodule
